// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg: shared FSM states, Avalon idle levels and default transfer geometry
package weight_loader_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam int          CNT_W          = 21;
    localparam int          OUT_W          = 5;
    localparam logic        READ_N_IDLE    = 1'b1;
    localparam logic [1:0]  BE_IDLE        = 2'b11;
    localparam logic [31:0] DEF_SRC_BASE   = 32'd0;
    localparam logic [31:0] DEF_DST_BASE   = 32'h0400_0000;
    localparam int          DEF_WORD_COUNT = 157000;
endpackage

// File: rtl/weight_loader_if.sv
// weight_loader_if: Avalon SDRAM read port plus on-chip RAM write port
interface weight_loader_if;
    logic               read_n;
    logic               chipselect;
    logic               waitrequest;
    logic               readdatavalid;
    logic [31:0]        address;
    logic [1:0]         byteenable;
    logic signed [15:0] readdata;
    logic [31:0]        addressOnChip;
    logic               chipselectOnChip;
    logic               write;
    logic [1:0]         byteenableOnChip;
    logic signed [15:0] writeDataOnChip;
    modport master (
        output read_n, chipselect, address, byteenable,
        output addressOnChip, chipselectOnChip, write, byteenableOnChip, writeDataOnChip,
        input  waitrequest, readdatavalid, readdata
    );
    modport slave (
        input  read_n, chipselect, address, byteenable,
        input  addressOnChip, chipselectOnChip, write, byteenableOnChip, writeDataOnChip,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/weight_loader_credit.sv
// weight_loader_credit: outstanding-read counter; full looks at the post-edge count so read_n can be registered against it
module weight_loader_credit
    import weight_loader_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic dec,
    output logic full
);
    logic [OUT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = cnt_q + OUT_W'(inc) - OUT_W'(dec);
    assign full = cnt_d >= OUT_W'(MAX);
    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/weight_loader.sv
// weight_loader: streams WORD_COUNT words from SDRAM into on-chip RAM with bounded outstanding reads
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter logic [31:0] SRC_BASE        = DEF_SRC_BASE,
    parameter logic [31:0] DST_BASE        = DEF_DST_BASE,
    parameter int          WORD_COUNT      = DEF_WORD_COUNT,
    parameter int          MAX_OUTSTANDING = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            startSig,
    output logic            doneSig,
    output logic            busy,
    output logic [31:0]     checksum,
    weight_loader_if.master bus
);
    localparam logic [CNT_W-1:0] WC = CNT_W'(WORD_COUNT);
    state_t             state_q, state_d;
    logic               prev_start_q, prev_start_d;
    logic [CNT_W-1:0]   issued_q, issued_d, received_q, received_d;
    logic [31:0]        checksum_q, checksum_d, address_q, address_d, addr_oc_q, addr_oc_d;
    logic               read_n_q, read_n_d, write_q, write_d, done_q, done_d, busy_q, busy_d;
    logic signed [15:0] wdata_q, wdata_d;
    logic               accept, take, full;
    assign accept = !read_n_q && !bus.waitrequest;
    // returns that arrive after an abandoned transfer must not touch the credit count
    assign take   = bus.readdatavalid && state_q != IDLE;
    weight_loader_credit #(.MAX(MAX_OUTSTANDING)) u_credit (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (accept),
        .dec     (take),
        .full    (full)
    );
    always_comb begin
        state_d      = state_q;
        prev_start_d = startSig;
        issued_d     = issued_q;
        received_d   = received_q;
        checksum_d   = checksum_q;
        read_n_d     = read_n_q;
        address_d    = address_q;
        write_d      = 1'b0;
        addr_oc_d    = addr_oc_q;
        wdata_d      = wdata_q;
        done_d       = done_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: if (startSig && !prev_start_q) begin
                state_d    = ISSUE;
                issued_d   = '0;
                received_d = '0;
                checksum_d = '0;
                done_d     = 1'b0;
                busy_d     = 1'b1;
                read_n_d   = 1'b0;
                address_d  = SRC_BASE;
            end
            ISSUE: begin
                issued_d  = issued_q + CNT_W'(accept);
                read_n_d  = !(issued_d < WC && !full);
                address_d = SRC_BASE + 32'(issued_d);
                state_d   = issued_d == WC ? DRAIN : ISSUE;
            end
            DRAIN: if (received_q == WC) begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            write_d    = 1'b1;
            addr_oc_d  = DST_BASE + 32'(received_q);
            wdata_d    = bus.readdata;
            received_d = received_q + CNT_W'(1);
            checksum_d = checksum_q + {{16{bus.readdata[15]}}, bus.readdata};
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            prev_start_q <= 1'b1;
            issued_q     <= '0;
            received_q   <= '0;
            checksum_q   <= '0;
            read_n_q     <= READ_N_IDLE;
            address_q    <= '0;
            write_q      <= 1'b0;
            addr_oc_q    <= DST_BASE;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_start_q <= prev_start_d;
            issued_q     <= issued_d;
            received_q   <= received_d;
            checksum_q   <= checksum_d;
            read_n_q     <= read_n_d;
            address_q    <= address_d;
            write_q      <= write_d;
            addr_oc_q    <= addr_oc_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end
    assign bus.read_n           = read_n_q;
    assign bus.chipselect       = busy_q;
    assign bus.address          = address_q;
    assign bus.byteenable       = BE_IDLE;
    assign bus.addressOnChip    = addr_oc_q;
    assign bus.chipselectOnChip = busy_q;
    assign bus.write            = write_q;
    assign bus.byteenableOnChip = BE_IDLE;
    assign bus.writeDataOnChip  = wdata_q;
    assign doneSig              = done_q;
    assign busy                 = busy_q;
    assign checksum             = checksum_q;
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: four loader configurations sharing one memory responder and a transfer-level reference model
module tb_weight_loader;
    typedef struct {int due; logic [15:0] data;} pend_t;
    logic        clk = 1'b0;
    logic        rst_n, start;
    int          sel, lat, stall_n;
    bit          wr_rand;
    logic        wr = 1'b0, rdv = 1'b0;
    logic [15:0] rdata = '0;
    logic [15:0] mem [16];
    int          ecnt = 0, checks = 0, errors = 0;
    int          acc_cnt = 0, out = 0, maxo = 0, coinc = 0, stalled = 0, stall_ok = 0;
    int          bad_rn = 0, bad_addr = 0, bad_cs = 0;
    logic        st_prev = 1'b0, stall_now, acc, rv;
    pend_t       pend [$];
    logic [31:0] acc_q [$], wa_q [$];
    logic [15:0] wd_q [$];
    logic        rn_a [4], cs_a [4], w_a [4], cso_a [4], done_a [4], busy_a [4];
    logic [31:0] ad_a [4], aoc_a [4], cks_a [4];
    logic [15:0] wd_a [4];
    logic [1:0]  be_a [4], beo_a [4];
    weight_loader_if bus [4] ();
    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;
    for (genvar g = 0; g < 4; g++) begin : g_tap
        assign bus[g].waitrequest   = wr;
        assign bus[g].readdatavalid = rdv;
        assign bus[g].readdata      = rdata;
        assign rn_a[g]  = bus[g].read_n;
        assign cs_a[g]  = bus[g].chipselect;
        assign ad_a[g]  = bus[g].address;
        assign be_a[g]  = bus[g].byteenable;
        assign aoc_a[g] = bus[g].addressOnChip;
        assign cso_a[g] = bus[g].chipselectOnChip;
        assign w_a[g]   = bus[g].write;
        assign beo_a[g] = bus[g].byteenableOnChip;
        assign wd_a[g]  = bus[g].writeDataOnChip;
    end
    weight_loader #(.WORD_COUNT(4)) u_a (
        .clk(clk), .reset_n(rst_n), .startSig(start && sel == 0), .doneSig(done_a[0]),
        .busy(busy_a[0]), .checksum(cks_a[0]), .bus(bus[0]));
    weight_loader #(.SRC_BASE(32'h100), .DST_BASE(32'h2000), .WORD_COUNT(8), .MAX_OUTSTANDING(2)) u_b (
        .clk(clk), .reset_n(rst_n), .startSig(start && sel == 1), .doneSig(done_a[1]),
        .busy(busy_a[1]), .checksum(cks_a[1]), .bus(bus[1]));
    weight_loader #(.WORD_COUNT(1)) u_c (
        .clk(clk), .reset_n(rst_n), .startSig(start && sel == 2), .doneSig(done_a[2]),
        .busy(busy_a[2]), .checksum(cks_a[2]), .bus(bus[2]));
    weight_loader #(.SRC_BASE(32'h40), .DST_BASE(32'h300), .WORD_COUNT(8)) u_d (
        .clk(clk), .reset_n(rst_n), .startSig(start && sel == 3), .doneSig(done_a[3]),
        .busy(busy_a[3]), .checksum(cks_a[3]), .bus(bus[3]));
    function automatic int wc_of(input int g);
        return g == 0 ? 4 : g == 2 ? 1 : 8;
    endfunction
    function automatic int mx_of(input int g);
        return g == 1 ? 2 : 8;
    endfunction
    function automatic logic [31:0] src_of(input int g);
        return g == 1 ? 32'h100 : g == 3 ? 32'h40 : 32'h0;
    endfunction
    function automatic logic [31:0] dst_of(input int g);
        return g == 1 ? 32'h2000 : g == 3 ? 32'h300 : 32'h0400_0000;
    endfunction
    // memory responder and bus observer; all decisions made at negedge for the following posedge
    always @(negedge clk) begin
        if (start && !st_prev) begin
            acc_cnt = 0; out = 0; maxo = 0; coinc = 0; stalled = 0; stall_ok = 0;
            bad_rn = 0; bad_addr = 0; bad_cs = 0;
            acc_q.delete(); wa_q.delete(); wd_q.delete();
        end
        st_prev = start;
        if (!rst_n) begin
            out = 0;
            while (pend.size() > 2) void'(pend.pop_back());
        end
        if (busy_a[sel]) begin
            if (rn_a[sel] !== !(acc_cnt < wc_of(sel) && out < mx_of(sel))) bad_rn++;
            if (!rn_a[sel] && ad_a[sel] !== src_of(sel) + acc_cnt) bad_addr++;
        end
        if (cs_a[sel] !== busy_a[sel] || cso_a[sel] !== busy_a[sel]) bad_cs++;
        if (w_a[sel] === 1'b1) begin
            wa_q.push_back(aoc_a[sel]);
            wd_q.push_back(wd_a[sel]);
        end
        stall_now = stall_n > 0 && acc_cnt == 1 && stalled < stall_n && busy_a[sel] && !rn_a[sel];
        wr = stall_now || (wr_rand && $urandom_range(3) == 0);
        if (stall_now) begin
            stalled++;
            if (ad_a[sel] === src_of(sel) + 1) stall_ok++;
        end
        acc = !rn_a[sel] && !wr && rst_n;
        rv  = pend.size() > 0 && pend[0].due <= ecnt + 1;
        rdv = rv;
        if (rv) begin
            rdata = pend[0].data;
            void'(pend.pop_front());
            if (out > 0) out--;
        end
        if (acc) begin
            pend.push_back('{due: ecnt + 1 + lat, data: mem[ad_a[sel][3:0]]});
            acc_q.push_back(ad_a[sel]);
            acc_cnt++;
            out++;
        end
        if (acc && rv) coinc++;
        if (out > maxo) maxo = out;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic do_run(input int g, input int bound, input bit hold, input bit rand_mem);
        int          n;
        logic [31:0] sum;
        logic [15:0] d;
        sel = g;
        if (rand_mem) for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        chk(32'(busy_a[g]), 1, "busy_at_start");
        n = 0;
        while (done_a[g] !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(32'(done_a[g]), 1, "done_within_bound");
        chk(32'(busy_a[g]), 0, "busy_after_done");
        chk(wa_q.size(), wc_of(g), "write_count");
        chk(acc_q.size(), wc_of(g), "read_count");
        sum = 0;
        for (int i = 0; i < wc_of(g); i++) begin
            d = mem[(src_of(g) + i) % 16];
            sum += {{16{d[15]}}, d};
            chk(acc_q[i], src_of(g) + i, "read_addr");
            chk(wa_q[i], dst_of(g) + i, "write_addr");
            chk({16'h0, wd_q[i]}, {16'h0, d}, "write_data");
        end
        chk(cks_a[g], sum, "checksum");
        chk(bad_rn, 0, "read_n_vs_credit");
        chk(bad_addr, 0, "read_address_track");
        chk(bad_cs, 0, "chipselect_vs_busy");
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        rst_n = 1'b0; start = 1'b0; sel = 0; lat = 3; wr_rand = 0; stall_n = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) tick();
        chk(32'(rn_a[0]), 1, "rst_read_n");
        chk(32'(cs_a[0]), 0, "rst_chipselect");
        chk(ad_a[0], 0, "rst_address");
        chk(32'(w_a[0]), 0, "rst_write");
        chk(32'(cso_a[0]), 0, "rst_cs_onchip");
        chk(aoc_a[0], 32'h0400_0000, "rst_addr_onchip");
        chk(aoc_a[1], 32'h2000, "rst_addr_onchip_b");
        chk(32'(wd_a[0]), 0, "rst_wdata");
        chk(32'(be_a[0]), 3, "rst_byteenable");
        chk(32'(beo_a[0]), 3, "rst_byteenable_onchip");
        chk(32'(done_a[0]), 0, "rst_done");
        chk(32'(busy_a[0]), 0, "rst_busy");
        chk(cks_a[0], 0, "rst_checksum");
        rst_n = 1'b1;
        repeat (2) tick();
        mem[0] = 16'd1; mem[1] = 16'hFFFE; mem[2] = 16'd3; mem[3] = 16'hFFFC;
        do_run(0, 10, 0, 0);
        chk(cks_a[0], 32'hFFFF_FFFE, "checksum_signed_sum");
        tick();
        stall_n = 5;
        do_run(0, 100, 0, 1);
        chk(stall_ok, 5, "stall_holds_second_address");
        stall_n = 0;
        tick();
        do_run(0, 100, 1, 1);
        repeat (50) tick();
        chk(32'(done_a[0]), 1, "held_start_done_sticky");
        chk(32'(busy_a[0]), 0, "held_start_no_retrigger");
        chk(acc_q.size(), 4, "held_start_single_transfer");
        start = 1'b0;
        tick();
        for (int r = 0; r < 3; r++) begin
            lat = $urandom_range(1, 6);
            wr_rand = 1;
            do_run(0, 200, 0, 1);
            tick();
        end
        lat = 20; wr_rand = 0;
        do_run(1, 400, 0, 1);
        chk(maxo, 2, "max_outstanding");
        chk(32'(coinc > 0), 1, "accept_with_return_seen");
        tick();
        lat = $urandom_range(1, 6); wr_rand = 1;
        do_run(1, 400, 0, 1);
        tick();
        do_run(2, 100, 0, 1);
        tick();
        lat = 6; wr_rand = 0;
        sel = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; acc_cnt < 3 && n < 50; n++) tick();
        chk(acc_cnt, 3, "three_accepts_before_reset");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk(wa_q.size(), 0, "stale_returns_no_write");
        chk(32'(busy_a[3]), 0, "reset_abandon_busy");
        chk(32'(done_a[3]), 0, "reset_abandon_done");
        chk(cks_a[3], 0, "reset_abandon_checksum");
        chk(32'(rn_a[3]), 1, "reset_abandon_read_n");
        lat = $urandom_range(1, 6); wr_rand = 1;
        do_run(3, 300, 0, 1);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 The block SHALL have parameter SRC_BASE, default 32'd0: SDRAM word address of the first weight.
REQ-002 The block SHALL have parameter DST_BASE, default 32'h04000000: on-chip word address of the first weight.
REQ-003 The block SHALL have parameter WORD_COUNT, default 157000: 16-bit words per transfer; legal range 1..2^20.
REQ-004 The block SHALL have parameter MAX_OUTSTANDING, default 8: maximum accepted-but-unreturned reads; legal range 1..16.
REQ-005 The block SHALL have port clk, input, 1: sole clock.
REQ-006 The block SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-007 The block SHALL have port startSig, input, 1: a rising edge launches one transfer.
REQ-008 The block SHALL have port doneSig, output, 1: sticky transfer-complete flag; it drives sdram_master startSig.
REQ-009 The block SHALL have port busy, output, 1: high while a transfer is in progress.
REQ-010 The block SHALL have port read_n, output, 1: Avalon read request, active low.
REQ-011 The block SHALL have port chipselect, output, 1: SDRAM select.
REQ-012 The block SHALL have ports waitrequest (input, 1) and readdatavalid (input, 1): Avalon stall and read-return strobe.
REQ-013 The block SHALL have ports address (output, 32) and byteenable (output, 2): SDRAM word address and lane enables.
REQ-014 The block SHALL have port readdata, input, signed 16: SDRAM return data.
REQ-015 The block SHALL have ports addressOnChip (output, 32), chipselectOnChip (output, 1), write (output, 1), byteenableOnChip (output, 2) and writeDataOnChip (output, signed 16): on-chip RAM write port.
REQ-016 The block SHALL have port checksum, output, 32: running two's-complement sum of all words written.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and DRAIN; all outputs SHALL be registered.
REQ-018 IDLE SHALL go to ISSUE on a startSig rising edge, detected as startSig=1 with the previous-cycle startSig=0. This transition SHALL clear the issue count, receive count and checksum, and SHALL set doneSig=0 and busy=1.
REQ-019 startSig edges in ISSUE or DRAIN SHALL be ignored, and a startSig held high SHALL NOT retrigger.
REQ-020 In ISSUE, read_n SHALL be 0 only while issued<WORD_COUNT and outstanding<MAX_OUTSTANDING, and address SHALL equal SRC_BASE+issued.
REQ-021 A read SHALL count as accepted on any edge where read_n=0 and waitrequest=0; address and read_n SHALL be held stable while waitrequest=1.
REQ-022 outstanding SHALL be accepted minus returned; a simultaneous accept and readdatavalid SHALL leave it unchanged, and it SHALL never exceed MAX_OUTSTANDING.
REQ-023 On the edge that accepts read number WORD_COUNT, the FSM SHALL enter DRAIN with read_n=1.
REQ-024 Each readdatavalid=1 in ISSUE or DRAIN SHALL produce, one cycle later, write=1 with addressOnChip=DST_BASE+received and writeDataOnChip=readdata; received SHALL then increment and checksum += sign-extended readdata, modulo 2^32.
REQ-025 readdatavalid in IDLE SHALL be ignored and SHALL produce no write.
REQ-026 In DRAIN, the cycle that issues on-chip write number WORD_COUNT SHALL be followed by IDLE, doneSig=1 and busy=0; doneSig SHALL stay 1 until the next accepted start.
REQ-027 byteenable and byteenableOnChip SHALL be constant 2'b11, chipselect SHALL be 1 while busy, chipselectOnChip SHALL be 1 while busy, and write_n SHALL NOT exist because the block never writes SDRAM.
REQ-028 Counters SHALL be 21 bits wide and outstanding SHALL be 5 bits wide; address arithmetic SHALL be 32-bit and SHALL NOT wrap within legal parameters.

Reset
REQ-029 reset_n=0 at an edge SHALL force IDLE with: read_n=1, chipselect=0, address=0, write=0, chipselectOnChip=0, addressOnChip=DST_BASE, writeDataOnChip=0, byteenable=2'b11, byteenableOnChip=2'b11, doneSig=0, busy=0, checksum=0, all counters=0, and the previous-start register=1.
REQ-030 A reset in mid-transfer SHALL abandon all outstanding reads; their late readdatavalid strobes SHALL be ignored per REQ-025.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the Avalon idle constants (read_n=1, byteenable=2'b11) and the default SRC_BASE, DST_BASE and WORD_COUNT.
REQ-032 The outstanding-read tracker SHALL be a single sub-module, weight_loader_credit, taking inc/dec inputs and providing a full output.

Verification
REQ-033 Scenario: WORD_COUNT=4, waitrequest=0, fixed 3-cycle read latency, data 1,-2,3,-4 -> on-chip writes at 0x04000000..0x04000003, checksum=0xFFFFFFFE, and doneSig=1 within 10 cycles of the start.
REQ-034 Scenario: waitrequest held 1 for 5 cycles on the 2nd request -> address stays SRC_BASE+1 and read_n stays 0 throughout, with no duplicate or skipped address.
REQ-035 Scenario: MAX_OUTSTANDING=2 with 20-cycle read latency -> read_n=1 while 2 reads are outstanding, and an accept coinciding with readdatavalid leaves outstanding=2.
REQ-036 Scenario: startSig held high for 50 cycles after completion -> exactly one transfer, and doneSig remains 1.
REQ-037 Scenario: reset_n=0 for 1 cycle after 3 of 8 accepts, then 2 stale readdatavalid pulses -> no on-chip writes, and IDLE with doneSig=0 and checksum=0.
REQ-038 Scenario: WORD_COUNT=1 -> exactly one read, one write at DST_BASE, then doneSig=1.
